dds_iq_demod: RTL and testbench

Lock-in I/Q demodulator. Receive-side counterpart of the DDS excitation path in the impedance-measurement chain. Multiplies each measured ADC sample by the DDS sine/cosine reference of the same instant and accumulates both products over a programmed number of samples. The controller converts the resulting I/Q sums into magnitude and phase.

---
 rtl/demod_pkg.sv | 36 +++
 rtl/demod_mac.sv | 103 ++++++++++
 rtl/dds_iq_demod.sv | 142 ++++++++++++++
 tb/tb_dds_iq_demod.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demod_pkg.sv
// Shared types and constants for the dds_iq_demod lock-in demodulator.
// The saturating-add helper is only referenced when DEMOD_OVF_DETECT_EN is defined.
package demod_pkg;

  // Measurement sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ACCUM  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Saturation direction of an accumulator lane.
  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_POS  = 2'd1,
    SAT_NEG  = 2'd2
  } sat_e;

  localparam int DEF_DATA_W   = 14;
  localparam int PROD_W       = 2 * DEF_DATA_W;
  localparam int DRAIN_CYCLES = 2;

  // Saturating-add decision for a two's-complement add of any width: given the
  // sign bits of both operands and of the wrapped sum, report which rail (if any)
  // the result must be clamped to.
  function automatic sat_e sat_add_dir(input logic a_msb, input logic b_msb,
                                       input logic sum_msb);
    if ((a_msb == b_msb) && (sum_msb != a_msb)) begin
      return a_msb ? SAT_NEG : SAT_POS;
    end
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/demod_mac.sv
// One multiply-accumulate lane of the I/Q demodulator: registered full-precision
// product, then sign-extended accumulate. With DEMOD_OVF_DETECT_EN defined the
// accumulate saturates and latches the saturation direction; otherwise it wraps.
module demod_mac
  import demod_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = 48
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear_i,
  input  logic                     sample_en_i,
  input  logic signed [DATA_W-1:0] adc_i,
  input  logic signed [DATA_W-1:0] ref_i,
  output logic signed [ACC_W-1:0]  acc_o,
  output logic                     ovf_o
);

  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0]    prod_q;
  logic                    prod_vld_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;

  assign prod_ext = {{(ACC_W - PW){prod_q[PW-1]}}, prod_q};
  assign sum      = acc_q + prod_ext;
  assign acc_o    = acc_q;

  // Stage 1: capture the signed product of each accepted sample.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
    end else if (clear_i) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
    end else begin
      prod_vld_q <= sample_en_i;
      if (sample_en_i) begin
        prod_q <= adc_i * ref_i;
      end
    end
  end

`ifdef DEMOD_OVF_DETECT_EN
  sat_e sat_q;
  sat_e sat_dir;

  assign sat_dir = sat_add_dir(acc_q[ACC_W-1], prod_ext[ACC_W-1], sum[ACC_W-1]);
  assign ovf_o   = (sat_q != SAT_NONE);

  // Stage 2 next value: add, clamp on overflow, freeze once saturated.
  // NOTE: the default assignment first keeps this always_comb latch-free.
  always_comb begin
    acc_d = acc_q;
    if (prod_vld_q && (sat_q == SAT_NONE)) begin
      case (sat_dir)
        SAT_POS: acc_d = {1'b0, {(ACC_W - 1){1'b1}}};
        SAT_NEG: acc_d = {1'b1, {(ACC_W - 1){1'b0}}};
        default: acc_d = sum;
      endcase
    end
  end

  // Sticky saturation direction, cleared when a new measurement starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_q <= SAT_NONE;
    end else if (clear_i) begin
      sat_q <= SAT_NONE;
    end else if (prod_vld_q && (sat_q == SAT_NONE)) begin
      sat_q <= sat_dir;
    end
  end
`else
  assign ovf_o = 1'b0;

  // Stage 2 next value: plain wrapping add.
  always_comb begin
    acc_d = acc_q;
    if (prod_vld_q) begin
      acc_d = sum;
    end
  end
`endif

  // Stage 2 register: working accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/dds_iq_demod.sv
// Lock-in I/Q demodulator: discards a settle window, then accumulates
// adc*cos (I) and adc*sin (Q) over n samples and publishes the sums.
// Optional overflow saturation/flag: define DEMOD_OVF_DETECT_EN.
module dds_iq_demod
  import demod_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 20,
  parameter int ACC_W  = 48
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [CNT_W-1:0]         n_samples_i,
  input  logic [CNT_W-1:0]         settle_i,
  input  logic                     sample_valid_i,
  input  logic signed [DATA_W-1:0] adc_i,
  input  logic signed [DATA_W-1:0] ref_sin_i,
  input  logic signed [DATA_W-1:0] ref_cos_i,
  output logic signed [ACC_W-1:0]  i_acc_o,
  output logic signed [ACC_W-1:0]  q_acc_o,
  output logic                     result_valid_o,
  output logic                     busy_o,
  output logic                     ovf_o
);

  state_e                  state_q;
  logic [CNT_W-1:0]        n_q;
  logic [CNT_W-1:0]        settle_cnt_q;
  logic [CNT_W-1:0]        acc_cnt_q;
  logic [1:0]              drain_cnt_q;
  logic signed [ACC_W-1:0] i_acc_q;
  logic signed [ACC_W-1:0] q_acc_q;
  logic                    result_valid_q;
  logic signed [ACC_W-1:0] i_work;
  logic signed [ACC_W-1:0] q_work;
  logic                    i_ovf;
  logic                    q_ovf;
  logic                    accept;
  logic                    clear;

  // Samples only enter the MAC lanes while accumulating; a start clears them.
  assign accept = (state_q == ST_ACCUM) && sample_valid_i;
  assign clear  = (state_q == ST_IDLE) && start_i;

  assign i_acc_o        = i_acc_q;
  assign q_acc_o        = q_acc_q;
  assign result_valid_o = result_valid_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign ovf_o          = i_ovf | q_ovf;

  demod_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac_i (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (clear),
    .sample_en_i (accept),
    .adc_i       (adc_i),
    .ref_i       (ref_cos_i),
    .acc_o       (i_work),
    .ovf_o       (i_ovf)
  );

  demod_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac_q (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (clear),
    .sample_en_i (accept),
    .adc_i       (adc_i),
    .ref_i       (ref_sin_i),
    .acc_o       (q_work),
    .ovf_o       (q_ovf)
  );

  // Measurement sequencer, counters and registered result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      n_q            <= '0;
      settle_cnt_q   <= '0;
      acc_cnt_q      <= '0;
      drain_cnt_q    <= '0;
      i_acc_q        <= '0;
      q_acc_q        <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if (abort_i && (state_q != ST_IDLE)) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              n_q          <= n_samples_i;
              settle_cnt_q <= settle_i;
              acc_cnt_q    <= '0;
              drain_cnt_q  <= '0;
              if (settle_i != '0) begin
                state_q <= ST_SETTLE;
              end else if (n_samples_i != '0) begin
                state_q <= ST_ACCUM;
              end else begin
                state_q <= ST_DONE;
              end
            end
          end
          ST_SETTLE: begin
            if (sample_valid_i) begin
              settle_cnt_q <= settle_cnt_q - 1'b1;
              if (settle_cnt_q == CNT_W'(1)) begin
                state_q <= (n_q != '0) ? ST_ACCUM : ST_DONE;
              end
            end
          end
          ST_ACCUM: begin
            if (sample_valid_i) begin
              acc_cnt_q <= acc_cnt_q + 1'b1;
              if ((acc_cnt_q + 1'b1) == n_q) begin
                state_q <= ST_DRAIN;
              end
            end
          end
          ST_DRAIN: begin
            if (drain_cnt_q == 2'(DRAIN_CYCLES - 1)) begin
              state_q <= ST_DONE;
            end else begin
              drain_cnt_q <= drain_cnt_q + 1'b1;
            end
          end
          ST_DONE: begin
            i_acc_q        <= i_work;
            q_acc_q        <= q_work;
            result_valid_q <= 1'b1;
            state_q        <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_iq_demod.sv
// Directed self-checking bench for dds_iq_demod. A second instance with a
// 30-bit accumulator exercises overflow; expectations follow DEMOD_OVF_DETECT_EN.
module tb_dds_iq_demod;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start_i;
  logic               abort_i;
  logic [19:0]        n_samples_i;
  logic [19:0]        settle_i;
  logic               sample_valid_i;
  logic signed [13:0] adc_i;
  logic signed [13:0] ref_sin_i;
  logic signed [13:0] ref_cos_i;

  logic signed [47:0] i_acc_o;
  logic signed [47:0] q_acc_o;
  logic               result_valid_o;
  logic               busy_o;
  logic               ovf_o;

  logic signed [29:0] n_i_acc;
  logic signed [29:0] n_q_acc;
  logic               n_result_valid;
  logic               n_busy;
  logic               n_ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dds_iq_demod #(.DATA_W(14), .CNT_W(20), .ACC_W(48)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .n_samples_i    (n_samples_i),
    .settle_i       (settle_i),
    .sample_valid_i (sample_valid_i),
    .adc_i          (adc_i),
    .ref_sin_i      (ref_sin_i),
    .ref_cos_i      (ref_cos_i),
    .i_acc_o        (i_acc_o),
    .q_acc_o        (q_acc_o),
    .result_valid_o (result_valid_o),
    .busy_o         (busy_o),
    .ovf_o          (ovf_o)
  );

  dds_iq_demod #(.DATA_W(14), .CNT_W(20), .ACC_W(30)) dut_n (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .n_samples_i    (n_samples_i),
    .settle_i       (settle_i),
    .sample_valid_i (sample_valid_i),
    .adc_i          (adc_i),
    .ref_sin_i      (ref_sin_i),
    .ref_cos_i      (ref_cos_i),
    .i_acc_o        (n_i_acc),
    .q_acc_o        (n_q_acc),
    .result_valid_o (n_result_valid),
    .busy_o         (n_busy),
    .ovf_o          (n_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_meas(input int n, input int s);
    start_i     = 1'b1;
    n_samples_i = 20'(n);
    settle_i    = 20'(s);
    tick();
    start_i = 1'b0;
  endtask

  task automatic set_sample(input int a, input int c, input int s);
    adc_i     = 14'(a);
    ref_cos_i = 14'(c);
    ref_sin_i = 14'(s);
  endtask

  // Bounded wait for the result pulse; returns the number of cycles waited.
  task automatic wait_result(input int max_cyc, output int cyc);
    cyc = 0;
    while ((result_valid_o !== 1'b1) && (cyc < max_cyc)) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    start_i        = 1'b0;
    abort_i        = 1'b0;
    n_samples_i    = '0;
    settle_i       = '0;
    sample_valid_i = 1'b0;
    set_sample(0, 0, 0);
    #12;
    checks++;
    if ({i_acc_o, q_acc_o, result_valid_o, busy_o, ovf_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got i=%0d q=%0d rv=%b busy=%b ovf=%b, want all 0",
               i_acc_o, q_acc_o, result_valid_o, busy_o, ovf_o);
    end
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_constant();
    int cyc;
    start_meas(4, 0);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL const_busy: busy=%b want 1", busy_o);
    end
    set_sample(100, 1000, -500);
    sample_valid_i = 1'b1;
    repeat (4) tick();
    wait_result(10, cyc);   // valid stays high: extra samples must be ignored
    sample_valid_i = 1'b0;
    checks++;
    if (cyc != 3) begin
      errors++;
      $display("FAIL const_latency: waited %0d cycles want 3", cyc);
    end
    checks++;
    if (i_acc_o !== 48'(400000) || q_acc_o !== 48'(-200000)) begin
      errors++;
      $display("FAIL const_iq: got i=%0d q=%0d want i=400000 q=-200000", i_acc_o, q_acc_o);
    end
    tick();
    checks++;
    if (busy_o !== 1'b0 || result_valid_o !== 1'b0 || i_acc_o !== 48'(400000)) begin
      errors++;
      $display("FAIL const_after: busy=%b rv=%b i=%0d want 0 0 400000",
               busy_o, result_valid_o, i_acc_o);
    end
  endtask

  task automatic test_settle_gaps();
    int cyc;
    int j = 0;
    start_meas(2, 3);
    for (int k = 0; k < 9; k++) begin
      sample_valid_i = (k % 2 == 0);
      if (sample_valid_i) begin
        if (j < 3) set_sample(999, 2, 3);
        else set_sample(10, 2, 3);
        j++;
      end
      tick();
    end
    sample_valid_i = 1'b0;
    wait_result(10, cyc);
    checks++;
    if (cyc != 3) begin
      errors++;
      $display("FAIL settle_latency: waited %0d cycles want 3", cyc);
    end
    checks++;
    if (i_acc_o !== 48'(40) || q_acc_o !== 48'(60)) begin
      errors++;
      $display("FAIL settle_iq: got i=%0d q=%0d want i=40 q=60", i_acc_o, q_acc_o);
    end
    tick();
  endtask

  task automatic test_sign_extremes();
    int cyc;
    start_meas(1, 0);
    set_sample(-8192, -8192, 8191);
    sample_valid_i = 1'b1;
    tick();
    sample_valid_i = 1'b0;
    wait_result(10, cyc);
    checks++;
    if (cyc != 3 || i_acc_o !== 48'(67108864) || q_acc_o !== 48'(-67100672)) begin
      errors++;
      $display("FAIL extremes: got wait=%0d i=%0d q=%0d want 3 67108864 -67100672",
               cyc, i_acc_o, q_acc_o);
    end
    tick();
  endtask

  task automatic test_n_zero();
    set_sample(55, 66, 77);
    sample_valid_i = 1'b1;
    start_meas(0, 0);
    checks++;
    if (result_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL nzero_early: rv=%b busy=%b want 0 1", result_valid_o, busy_o);
    end
    tick();
    sample_valid_i = 1'b0;
    checks++;
    if (result_valid_o !== 1'b1 || i_acc_o !== 48'(0) || q_acc_o !== 48'(0)) begin
      errors++;
      $display("FAIL nzero_result: rv=%b i=%0d q=%0d want 1 0 0", result_valid_o, i_acc_o, q_acc_o);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int cyc;
    start_meas(3, 0);
    set_sample(1, 1, 1);
    sample_valid_i = 1'b1;
    tick();
    start_i     = 1'b1;
    n_samples_i = 20'd1;
    settle_i    = 20'd5;
    tick();
    start_i = 1'b0;
    tick();
    sample_valid_i = 1'b0;
    wait_result(10, cyc);
    checks++;
    if (cyc != 3 || i_acc_o !== 48'(3) || q_acc_o !== 48'(3)) begin
      errors++;
      $display("FAIL busy_start: got wait=%0d i=%0d q=%0d want 3 3 3", cyc, i_acc_o, q_acc_o);
    end
    tick();
  endtask

  task automatic test_abort();
    bit seen;
    start_meas(5, 0);
    set_sample(7, 7, 7);
    sample_valid_i = 1'b1;
    repeat (2) tick();
    sample_valid_i = 1'b0;
    abort_i = 1'b1;
    start_i = 1'b1;
    tick();
    abort_i = 1'b0;
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: busy=%b want 0", busy_o);
    end
    seen = 1'b0;
    repeat (6) begin
      if (result_valid_o === 1'b1 || busy_o !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen || i_acc_o !== 48'(3) || q_acc_o !== 48'(3)) begin
      errors++;
      $display("FAIL abort_hold: spurious=%b i=%0d q=%0d want 0 3 3", seen, i_acc_o, q_acc_o);
    end
    // Abort arriving in DONE suppresses the result.
    start_meas(0, 0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checks++;
    if (result_valid_o !== 1'b0 || busy_o !== 1'b0 || i_acc_o !== 48'(3)) begin
      errors++;
      $display("FAIL abort_done: rv=%b busy=%b i=%0d want 0 0 3", result_valid_o, busy_o, i_acc_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    start_meas(5, 0);
    set_sample(9, 9, 9);
    sample_valid_i = 1'b1;
    repeat (2) tick();
    reset_n = 1'b0;
    #2;
    checks++;
    if ({i_acc_o, q_acc_o, result_valid_o, busy_o, ovf_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got i=%0d q=%0d rv=%b busy=%b ovf=%b want all 0",
               i_acc_o, q_acc_o, result_valid_o, busy_o, ovf_o);
    end
    sample_valid_i = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_overflow();
    int cyc;
    logic signed [29:0] exp_i;
    logic signed [29:0] exp_q;
    logic               exp_ovf;
`ifdef DEMOD_OVF_DETECT_EN
    exp_i   = 30'(536870911);
    exp_q   = 30'(-536870912);
    exp_ovf = 1'b1;
`else
    exp_i   = 30'(-402653184);
    exp_q   = 30'(402735104);
    exp_ovf = 1'b0;
`endif
    start_meas(10, 0);
    set_sample(-8192, -8192, 8191);
    sample_valid_i = 1'b1;
    repeat (10) tick();
    sample_valid_i = 1'b0;
    wait_result(10, cyc);
    checks++;
    if (cyc != 3 || n_result_valid !== 1'b1 || n_i_acc !== exp_i || n_q_acc !== exp_q || n_ovf !== exp_ovf) begin
      errors++;
      $display("FAIL ovf_narrow: got wait=%0d rv=%b i=%0d q=%0d ovf=%b want 3 1 %0d %0d %b",
               cyc, n_result_valid, n_i_acc, n_q_acc, n_ovf, exp_i, exp_q, exp_ovf);
    end
    checks++;
    if (i_acc_o !== 48'(671088640) || q_acc_o !== 48'(-671006720) || ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_wide: got i=%0d q=%0d ovf=%b want 671088640 -671006720 0",
               i_acc_o, q_acc_o, ovf_o);
    end
    tick();
    checks++;
    if (n_ovf !== exp_ovf) begin
      errors++;
      $display("FAIL ovf_sticky: ovf=%b want %b", n_ovf, exp_ovf);
    end
    start_meas(0, 0);
    checks++;
    if (n_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b want 0", n_ovf);
    end
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_constant();
    test_settle_gaps();
    test_sign_extremes();
    test_n_zero();
    test_start_while_busy();
    test_abort();
    test_reset_mid();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
